// File: rtl/shift_out_tx_if.sv
// Word handshake between the core-side producer and the serial shift-out transmitter.
// The master offers a word with in_valid; the slave signals it can take one with in_ready.
interface shift_out_tx_if #(
    parameter int BITS = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in;

    modport master (
        output in_valid,
        output in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in,
        output in_ready
    );
endinterface

// File: rtl/shift_out_tx.sv
// Parallel-in, serial-out transmitter for a 74HC595-style chain.
// Shifts a captured word out MSB first on ser_clk, then pulses ser_latch so every output updates at once.
module shift_out_tx #(
    parameter int BITS = 8,
    parameter int DIV  = 1
) (
    input  logic           clk,
    input  logic           clear_n,
    shift_out_tx_if.slave  bus,
    output logic           ser_data,
    output logic           ser_clk,
    output logic           ser_latch,
    output logic           busy,
    output logic           done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0] BIT_FIRST  = BW'(BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_LATCH
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [PW-1:0]   r_phase;
    logic [PW-1:0]   w_phaseNext;
    logic [BW-1:0]   r_bitCnt;
    logic [BW-1:0]   w_bitCntNext;
    logic [BITS-1:0] r_shift;
    logic [BITS-1:0] w_shiftNext;
    logic            r_done;
    logic            w_doneNext;
    logic            w_phaseEnd;
    logic            w_idle;

    assign w_phaseEnd = (r_phase == PHASE_LAST);
    assign w_idle     = (r_state == S_IDLE);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_phase  <= w_phaseNext;
            r_bitCnt <= w_bitCntNext;
            r_shift  <= w_shiftNext;
            r_done   <= w_doneNext;
        end
    end

    // Every state lasts DIV cycles; the phase counter restarts on each state change.
    always_comb begin
        w_stateNext  = r_state;
        w_phaseNext  = r_phase;
        w_bitCntNext = r_bitCnt;
        w_shiftNext  = r_shift;
        w_doneNext   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_stateNext  = S_LOW;
                    w_phaseNext  = '0;
                    w_bitCntNext = BIT_FIRST;
                    w_shiftNext  = bus.in;
                end
            end
            S_LOW: begin
                if (w_phaseEnd) begin
                    w_phaseNext = '0;
                    w_stateNext = S_HIGH;
                end else begin
                    w_phaseNext = r_phase + 1'b1;
                end
            end
            S_HIGH: begin
                if (w_phaseEnd) begin
                    w_phaseNext = '0;
                    if (r_bitCnt != '0) begin
                        w_bitCntNext = r_bitCnt - 1'b1;
                        w_shiftNext  = r_shift << 1;
                        w_stateNext  = S_LOW;
                    end else begin
                        w_stateNext = S_LATCH;
                    end
                end else begin
                    w_phaseNext = r_phase + 1'b1;
                end
            end
            S_LATCH: begin
                if (w_phaseEnd) begin
                    w_phaseNext = '0;
                    w_stateNext = S_IDLE;
                    w_doneNext  = 1'b1;
                end else begin
                    w_phaseNext = r_phase + 1'b1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_phaseNext = '0;
            end
        endcase
    end

    // Data only changes when a new LOW phase begins, so it is settled well before each ser_clk rise.
    assign ser_data     = ((r_state == S_LOW) || (r_state == S_HIGH)) ? r_shift[BITS-1] : 1'b0;
    assign ser_clk      = (r_state == S_HIGH);
    assign ser_latch    = (r_state == S_LATCH);
    assign bus.in_ready = w_idle;
    assign busy         = ~w_idle;
    assign done         = r_done;

endmodule

// File: tb/tb_shift_out_tx.sv
// Self-checking bench for shift_out_tx: three instances (8/1, 8/3, 1/1) checked every cycle
// against a timeline model, plus directed transfers with hand-computed waveform landmarks.
module tb_shift_out_tx;

    logic clk = 1'b0;
    logic clear_n = 1'b0;

    always #5 clk = ~clk;

    shift_out_tx_if #(.BITS(8)) ifA ();
    shift_out_tx_if #(.BITS(8)) ifB ();
    shift_out_tx_if #(.BITS(1)) ifC ();

    logic [2:0] serData;
    logic [2:0] serClk;
    logic [2:0] serLatch;
    logic [2:0] busyO;
    logic [2:0] doneO;

    shift_out_tx #(.BITS(8), .DIV(1)) dutA (
        .clk(clk), .clear_n(clear_n), .bus(ifA),
        .ser_data(serData[0]), .ser_clk(serClk[0]), .ser_latch(serLatch[0]),
        .busy(busyO[0]), .done(doneO[0])
    );

    shift_out_tx #(.BITS(8), .DIV(3)) dutB (
        .clk(clk), .clear_n(clear_n), .bus(ifB),
        .ser_data(serData[1]), .ser_clk(serClk[1]), .ser_latch(serLatch[1]),
        .busy(busyO[1]), .done(doneO[1])
    );

    shift_out_tx #(.BITS(1), .DIV(1)) dutC (
        .clk(clk), .clear_n(clear_n), .bus(ifC),
        .ser_data(serData[2]), .ser_clk(serClk[2]), .ser_latch(serLatch[2]),
        .busy(busyO[2]), .done(doneO[2])
    );

    int nCompared = 0;
    int nMismatched = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: k counts cycles since the accept edge. 1..T busy, T+1 is the done cycle, 0 plain idle.
    function automatic logic [5:0] expOut(input int b, input int d, input logic [7:0] w, input int k);
        int t;
        int p;
        logic rdy, bsy, sc, sd, sl, dn;
        t = (2 * b + 1) * d;
        rdy = 1'b1; bsy = 1'b0; sc = 1'b0; sd = 1'b0; sl = 1'b0; dn = 1'b0;
        if (k >= 1 && k <= t) begin
            rdy = 1'b0;
            bsy = 1'b1;
            p = (k - 1) / d;
            if (p < 2 * b) begin
                sc = (p % 2) == 1;
                sd = w[b - 1 - p / 2];
            end else begin
                sl = 1'b1;
            end
        end else begin
            dn = (k == t + 1);
        end
        return {rdy, bsy, sc, sd, sl, dn};
    endfunction

    function automatic int nextK(input int k, input int t, input logic v);
        if ((k == 0 || k == t + 1) && v) return 1;
        if (k >= 1 && k <= t) return k + 1;
        return 0;
    endfunction

    int kA = 0, kB = 0, kC = 0;
    logic [7:0] wA = '0, wB = '0, wC = '0;

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            kA = 0; kB = 0; kC = 0;
        end else begin
            if ((kA == 0 || kA == 18) && ifA.in_valid) wA = ifA.in;
            if ((kB == 0 || kB == 52) && ifB.in_valid) wB = ifB.in;
            if ((kC == 0 || kC == 4) && ifC.in_valid) wC = {7'b0, ifC.in};
            kA = nextK(kA, 17, ifA.in_valid);
            kB = nextK(kB, 51, ifB.in_valid);
            kC = nextK(kC, 3, ifC.in_valid);
        end
    end

    always @(negedge clk) begin
        checkOutput("modelA", int'({ifA.in_ready, busyO[0], serClk[0], serData[0], serLatch[0], doneO[0]}),
                    int'(expOut(8, 1, wA, kA)));
        checkOutput("modelB", int'({ifB.in_ready, busyO[1], serClk[1], serData[1], serLatch[1], doneO[1]}),
                    int'(expOut(8, 3, wB, kB)));
        checkOutput("modelC", int'({ifC.in_ready, busyO[2], serClk[2], serData[2], serLatch[2], doneO[2]}),
                    int'(expOut(1, 1, wC, kC)));
    end

    int rises, highCycles, latchCycles, firstLatch, doneCount, firstDone, busyCycles, firstRise;
    logic readyAtDone;
    logic [15:0] bitsSeen;

    task automatic setIn(input int inst, input logic v, input logic [7:0] w);
        case (inst)
            0: begin ifA.in_valid = v; ifA.in = w; end
            1: begin ifB.in_valid = v; ifB.in = w; end
            default: begin ifC.in_valid = v; ifC.in = w[0]; end
        endcase
    endtask

    // Cycle 0 offers w1; from cycle 1 on the input shows w2, valid held while c < validCycles.
    task automatic applyStimulus(input int inst, input logic [7:0] w1, input logic [7:0] w2,
                                 input int validCycles, input int window);
        logic prevClk;
        logic sc, sd, sl, dn, bs, rd;
        rises = 0; highCycles = 0; latchCycles = 0; firstLatch = -1; doneCount = 0;
        firstDone = -1; busyCycles = 0; firstRise = -1; readyAtDone = 1'b0; bitsSeen = '0;
        prevClk = 1'b0;
        @(posedge clk); #1;
        setIn(inst, 1'b1, w1);
        for (int c = 1; c <= window; c++) begin
            @(posedge clk); #1;
            setIn(inst, c < validCycles, w2);
            @(negedge clk);
            sc = serClk[inst]; sd = serData[inst]; sl = serLatch[inst];
            dn = doneO[inst]; bs = busyO[inst];
            rd = (inst == 0) ? ifA.in_ready : (inst == 1) ? ifB.in_ready : ifC.in_ready;
            if (sc && !prevClk) begin
                rises++;
                if (firstRise < 0) firstRise = c;
                bitsSeen = {bitsSeen[14:0], sd};
            end
            if (sc) highCycles++;
            if (sl) begin
                latchCycles++;
                if (firstLatch < 0) firstLatch = c;
            end
            if (dn) begin
                doneCount++;
                if (firstDone < 0) begin
                    firstDone = c;
                    readyAtDone = rd;
                end
            end
            if (bs) busyCycles++;
            prevClk = sc;
        end
    endtask

    initial begin
        setIn(0, 1'b0, 8'h00);
        setIn(1, 1'b0, 8'h00);
        setIn(2, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", int'(ifA.in_ready), 1);
        checkOutput("rst_busy", int'(busyO), 0);
        checkOutput("rst_outs", int'({serData, serClk, serLatch, doneO}), 0);
        @(negedge clk); #2;
        clear_n = 1'b1;

        applyStimulus(0, 8'hA5, 8'hA5, 1, 20);
        checkOutput("A5_rises", rises, 8);
        checkOutput("A5_first_rise", firstRise, 2);
        checkOutput("A5_bits", int'(bitsSeen), 16'h00A5);
        checkOutput("A5_latch_cycles", latchCycles, 1);
        checkOutput("A5_latch_at", firstLatch, 17);
        checkOutput("A5_done_at", firstDone, 18);
        checkOutput("A5_ready_at_done", int'(readyAtDone), 1);
        checkOutput("A5_busy_cycles", busyCycles, 17);

        applyStimulus(1, 8'h81, 8'h81, 1, 55);
        checkOutput("div3_busy_cycles", busyCycles, 51);
        checkOutput("div3_high_cycles", highCycles, 24);
        checkOutput("div3_rises", rises, 8);
        checkOutput("div3_bits", int'(bitsSeen), 16'h0081);
        checkOutput("div3_latch_cycles", latchCycles, 3);
        checkOutput("div3_latch_at", firstLatch, 49);
        checkOutput("div3_done_at", firstDone, 52);

        applyStimulus(0, 8'hFF, 8'h00, 20, 40);
        checkOutput("b2b_latches", latchCycles, 2);
        checkOutput("b2b_dones", doneCount, 2);
        checkOutput("b2b_first_done", firstDone, 18);
        checkOutput("b2b_busy_cycles", busyCycles, 34);
        checkOutput("b2b_bits", int'(bitsSeen), 16'hFF00);

        applyStimulus(0, 8'h3C, 8'hFF, 18, 22);
        checkOutput("busyin_bits", int'(bitsSeen), 16'h003C);
        checkOutput("busyin_rises", rises, 8);
        checkOutput("busyin_dones", doneCount, 1);
        checkOutput("busyin_busy_cycles", busyCycles, 17);

        applyStimulus(0, 8'hF0, 8'hF0, 1, 8);
        checkOutput("rst_mid_rises", rises, 4);
        checkOutput("rst_mid_clk_before", int'(serClk[0]), 1);
        #2;
        clear_n = 1'b0;
        #1;
        checkOutput("rst_mid_clk", int'(serClk[0]), 0);
        checkOutput("rst_mid_data", int'(serData[0]), 0);
        checkOutput("rst_mid_latch", int'(serLatch[0]), 0);
        checkOutput("rst_mid_ready", int'(ifA.in_ready), 1);
        checkOutput("rst_mid_busy", int'(busyO[0]), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mid_no_done", int'(doneO[0]), 0);
        @(negedge clk); #2;
        clear_n = 1'b1;

        applyStimulus(0, 8'h5A, 8'h5A, 1, 20);
        checkOutput("5A_bits", int'(bitsSeen), 16'h005A);
        checkOutput("5A_done_at", firstDone, 18);
        checkOutput("5A_latch_at", firstLatch, 17);

        applyStimulus(2, 8'h01, 8'h01, 1, 6);
        checkOutput("b1_first_rise", firstRise, 2);
        checkOutput("b1_rises", rises, 1);
        checkOutput("b1_bits", int'(bitsSeen), 16'h0001);
        checkOutput("b1_latch_at", firstLatch, 3);
        checkOutput("b1_done_at", firstDone, 4);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
